// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_e : controller state (RUN / DRAIN / GRANT)
//   pipe_ctl_t   : bundle of pipeline-register enables
//   REG_W_DEF    : default register-index width
//   DRAIN_MAX    : largest legal DRAIN_CYCLES value
//   DRAIN_CNT_W  : width of the drain down-counter (holds 0..DRAIN_MAX-1)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GRANT = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
    } pipe_ctl_t;

    localparam int REG_W_DEF   = 5;
    localparam int DRAIN_MAX   = 15;
    localparam int DRAIN_CNT_W = 4;

    // Enable patterns shared by several states.
    localparam pipe_ctl_t CTL_NORMAL = '{pc_we: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1};
    localparam pipe_ctl_t CTL_STALL  = '{pc_we: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0};
    localparam pipe_ctl_t CTL_RESET  = '{pc_we: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0};

    // Taken-branch pattern while running: fetch the target, squash the
    // wrong-path instruction in IF/ID and bubble ID/EX.
    function automatic pipe_ctl_t branch_ctl(input logic keep_fetch_en);
        pipe_ctl_t c;
        c.pc_we      = 1'b1;
        c.ifid_en    = keep_fetch_en;
        c.ifid_flush = 1'b1;
        c.idex_en    = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard compare between the instruction in ID and a
// load in EX. Kept standalone so the forwarding unit can reuse it.
// Ports:
//   rs1, rs2   : source register indices of the ID instruction
//   uses_rs2   : ID instruction actually reads rs2
//   rd         : destination register of the EX instruction
//   mem_read   : EX instruction is a load
//   load_use   : 1 when ID must wait one cycle for the load data
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             uses_rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             mem_read,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Register 0 is hard-wired zero, so a load targeting it never creates a
    // dependency.
    assign rs1_hit  = (rd == rs1);
    assign rs2_hit  = uses_rs2 & (rd == rs2);
    assign load_use = mem_read & (rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Drives the IF/ID and ID/EX pipeline-register enables and the PC write
// enable. Handles load-use stalls, taken-branch flushes and DMA bus hand-off
// (drain the pipeline, grant, resume).
//
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   id_rs1, id_rs2    : source registers of the ID instruction
//   id_uses_rs2       : ID instruction reads rs2
//   ex_rd             : destination register of the EX instruction
//   ex_mem_read       : EX instruction is a load
//   ex_branch_taken   : branch resolved taken in EX this cycle
//   dma_req           : DMA bus request (level)
//   dma_ack           : bus granted to DMA (registered)
//   pc_we             : PC load enable
//   ifid_en           : IF/ID load enable (0 = hold)
//   ifid_flush        : IF/ID synchronous clear
//   idex_en           : ID/EX enable (0 = bubble)
//   stall_cnt         : cycles with pc_we=0 (HAZ_PERF_CNT_EN only)
//   flush_cnt         : cycles with ifid_flush=1 (HAZ_PERF_CNT_EN only)
//
// Optional build macro: HAZ_PERF_CNT_EN adds the saturating performance
// counters stall_cnt / flush_cnt.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             dma_req,
    output logic             dma_ack,
    output logic             pc_we,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > DRAIN_MAX || CNT_W < 1) begin : g_param_err
        $error("pipe_hazard_ctrl: DRAIN_CYCLES must be 1..15 and CNT_W >= 1");
    end

    // The counter is loaded with DRAIN_CYCLES-1 on the edge that enters DRAIN
    // and grants on the edge where it is already 0, so DRAIN lasts exactly
    // DRAIN_CYCLES cycles.
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_e             state;
    logic [DRAIN_CNT_W-1:0]  drain_cnt;
    logic                    load_use;
    pipe_ctl_t               ctl;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .uses_rs2 (id_uses_rs2),
        .rd       (ex_rd),
        .mem_read (ex_mem_read),
        .load_use (load_use)
    );

    // Enables are combinational from state and inputs. Reset overrides
    // everything so the pipeline registers are held and IF/ID is cleared.
    always_comb begin
        ctl = CTL_NORMAL;
        unique case (state)
            RUN: begin
                // A taken branch squashes the younger instruction, so any
                // load-use hazard against it is moot.
                if (ex_branch_taken) begin
                    ctl = branch_ctl(1'b1);
                end else if (load_use) begin
                    ctl = CTL_STALL;
                end else begin
                    ctl = CTL_NORMAL;
                end
            end
            DRAIN: begin
                ctl = CTL_STALL;
                // A branch still in flight must redirect fetch even while
                // draining; the held IF/ID instruction is wrong-path then.
                if (ex_branch_taken) begin
                    ctl.pc_we      = 1'b1;
                    ctl.ifid_flush = 1'b1;
                end
            end
            GRANT: begin
                ctl = CTL_STALL;
            end
            default: begin
                ctl = CTL_STALL;
            end
        endcase
        if (!rst_n) begin
            ctl = CTL_RESET;
        end
    end

    assign pc_we      = ctl.pc_we;
    assign ifid_en    = ctl.ifid_en;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_en    = ctl.idex_en;

    // DMA hand-off FSM. dma_ack is set and cleared on the same edges as the
    // GRANT entry/exit so it is a clean registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            dma_ack   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    // A taken branch defers the request by one cycle.
                    if (!ex_branch_taken && dma_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    if (!dma_req) begin
                        state     <= RUN;
                        drain_cnt <= '0;
                    end else if (drain_cnt == '0) begin
                        state   <= GRANT;
                        dma_ack <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                GRANT: begin
                    if (!dma_req) begin
                        state   <= RUN;
                        dma_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    drain_cnt <= '0;
                    dma_ack   <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctl.pc_we) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (ctl.ifid_flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`endif

endmodule
